// File: rtl/counter_dn_ld.sv
// ============================================================================
// counter_dn_ld : loadable down-counter with borrow-out, optional auto-reload
//                 and an IDLE/COUNT state machine reporting busy and done.
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module counter_dn_ld #(
  parameter int WIDTH  = 6,
  parameter int RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in_i,
  input  logic             ld_i,
  input  logic             cnt_en_i,
  output logic [WIDTH-1:0] par_out_o,
  output logic             bo_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // A load always wins over a decrement in the same cycle, in either state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (ld_i) begin
      cnt_d    = par_in_i;
      reload_d = par_in_i;
      state_d  = S_COUNT;
    end else if (state_q == S_COUNT && cnt_en_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        done_d = 1'b1;
        if (RELOAD != 0) begin
          cnt_d = reload_q;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  assign par_out_o = cnt_q;
  assign busy_o    = (state_q == S_COUNT);
  assign bo_o      = (state_q == S_COUNT) && (cnt_q == '0);
  assign done_o    = done_q;

endmodule

`default_nettype wire
